reservation_station: RTL

- Out-of-order issue buffer directly downstream of the dispatch stage. It accepts one non-memory instruction per cycle, whose operands are either values or ROB tags.
- Snoops the ALU and LSB common data buses (CDBs) to resolve tags. Issues at most one fully-ready entry per cycle to the ALU.
- Exports the next free slot and a full flag back to dispatch.
- Flushed by the ROB on misprediction.

---
 rtl/reservation_station_pkg.sv | 66 ++++++
 rtl/reservation_station_rs_select.sv | 20 ++
 rtl/reservation_station.sv | 138 +++++++++++++
 3 files changed

// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, opcodes, entry types and CDB snoop helpers for reservation_station
package reservation_station_pkg;
  localparam int RS_SIZE   = 16;
  localparam int RS_IDX_W  = 4;
  localparam int ROB_IDX_W = 4;
  localparam int OP_W      = 6;
  localparam int XLEN      = 32;

  typedef logic [OP_W-1:0]      op_bus_t;
  typedef logic [XLEN-1:0]      data_bus_t;
  typedef logic [ROB_IDX_W-1:0] rob_bus_t;
  typedef logic [RS_IDX_W-1:0]  rs_bus_t;

  localparam logic      ENABLE    = 1'b1;
  localparam logic      DISABLE   = 1'b0;
  localparam data_bus_t NULL_DATA = '0;

  localparam op_bus_t OP_NOP  = 6'd0;
  localparam op_bus_t OP_ADD  = 6'd1;
  localparam op_bus_t OP_SUB  = 6'd2;
  localparam op_bus_t OP_ADDI = 6'd3;
  localparam op_bus_t OP_AND  = 6'd4;
  localparam op_bus_t OP_OR   = 6'd5;

  typedef struct packed {
    logic      q_valid;
    rob_bus_t  q;
    data_bus_t v;
  } operand_t;

  typedef struct packed {
    logic      busy;
    op_bus_t   op;
    data_bus_t a;
    data_bus_t pc;
    rob_bus_t  reorder;
    operand_t  j;
    operand_t  k;
  } rs_entry_t;

  function automatic operand_t make_operand(input logic is_tag, input data_bus_t value);
    operand_t o;
    o.q_valid = is_tag;
    o.q       = is_tag ? value[ROB_IDX_W-1:0] : '0;
    o.v       = is_tag ? NULL_DATA : value;
    return o;
  endfunction

  // ALU broadcast takes precedence when both buses carry the same tag.
  function automatic operand_t snoop(input operand_t o,
                                     input logic alu_en, input rob_bus_t alu_tag, input data_bus_t alu_val,
                                     input logic lsb_en, input rob_bus_t lsb_tag, input data_bus_t lsb_val);
    operand_t r;
    r = o;
    if (o.q_valid) begin
      if (alu_en && alu_tag == o.q) begin
        r.q_valid = DISABLE;
        r.v       = alu_val;
      end else if (lsb_en && lsb_tag == o.q) begin
        r.q_valid = DISABLE;
        r.v       = lsb_val;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/reservation_station_rs_select.sv
// rtl/reservation_station_rs_select.sv - lowest-index priority encoder with valid flag
module rs_select #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order issue buffer with CDB wakeup; RS_PERF_CNT_EN adds perf counters
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 disp_en,
  input  logic [OP_W-1:0]      disp_op,
  input  logic [XLEN-1:0]      disp_a,
  input  logic [XLEN-1:0]      disp_pc,
  input  logic [ROB_IDX_W-1:0] disp_reorder,
  input  logic                 disp_type_j,
  input  logic [XLEN-1:0]      disp_value_j,
  input  logic                 disp_type_k,
  input  logic [XLEN-1:0]      disp_value_k,
  output logic [RS_IDX_W-1:0]  free_pos,
  output logic                 full,
  input  logic                 alu_cdb_en,
  input  logic [ROB_IDX_W-1:0] alu_cdb_tag,
  input  logic [XLEN-1:0]      alu_cdb_value,
  input  logic                 lsb_cdb_en,
  input  logic [ROB_IDX_W-1:0] lsb_cdb_tag,
  input  logic [XLEN-1:0]      lsb_cdb_value,
  output logic                 alu_en,
  output logic [OP_W-1:0]      alu_op,
  output logic [XLEN-1:0]      alu_vj,
  output logic [XLEN-1:0]      alu_vk,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_pc,
  output logic [ROB_IDX_W-1:0] alu_reorder
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_full_cnt
`endif
);
  rs_entry_t          entries [RS_SIZE];
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic               free_valid;
  logic               ready_valid;
  rs_bus_t            free_idx;
  rs_bus_t            ready_idx;
  operand_t           disp_j;
  operand_t           disp_k;

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = entries[i].busy;
      ready_vec[i] = entries[i].busy & ~entries[i].j.q_valid & ~entries[i].k.q_valid;
    end
  end

  rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_select (
    .req   (~busy_vec),
    .valid (free_valid),
    .idx   (free_idx)
  );

  rs_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_ready_select (
    .req   (ready_vec),
    .valid (ready_valid),
    .idx   (ready_idx)
  );

  assign free_pos = free_idx;
  assign full     = ~free_valid;

  // Same-cycle broadcasts are folded in so a dispatching operand never misses its producer.
  always_comb begin
    disp_j = snoop(make_operand(disp_type_j, disp_value_j), alu_cdb_en, alu_cdb_tag, alu_cdb_value,
                   lsb_cdb_en, lsb_cdb_tag, lsb_cdb_value);
    disp_k = snoop(make_operand(disp_type_k, disp_value_k), alu_cdb_en, alu_cdb_tag, alu_cdb_value,
                   lsb_cdb_en, lsb_cdb_tag, lsb_cdb_value);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) entries[i] <= '0;
      alu_en      <= DISABLE;
      alu_op      <= '0;
      alu_vj      <= '0;
      alu_vk      <= '0;
      alu_a       <= '0;
      alu_pc      <= '0;
      alu_reorder <= '0;
    end else if (!rdy) begin
      alu_en <= DISABLE;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) entries[i].busy <= DISABLE;
      alu_en <= DISABLE;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (entries[i].busy) begin
          entries[i].j <= snoop(entries[i].j, alu_cdb_en, alu_cdb_tag, alu_cdb_value,
                                lsb_cdb_en, lsb_cdb_tag, lsb_cdb_value);
          entries[i].k <= snoop(entries[i].k, alu_cdb_en, alu_cdb_tag, alu_cdb_value,
                                lsb_cdb_en, lsb_cdb_tag, lsb_cdb_value);
        end
      end
      if (ready_valid) begin
        alu_en                  <= ENABLE;
        alu_op                  <= entries[ready_idx].op;
        alu_vj                  <= entries[ready_idx].j.v;
        alu_vk                  <= entries[ready_idx].k.v;
        alu_a                   <= entries[ready_idx].a;
        alu_pc                  <= entries[ready_idx].pc;
        alu_reorder             <= entries[ready_idx].reorder;
        entries[ready_idx].busy <= DISABLE;
      end else begin
        alu_en <= DISABLE;
      end
      if (disp_en && !full) begin
        entries[free_pos] <= '{busy: ENABLE, op: disp_op, a: disp_a, pc: disp_pc,
                               reorder: disp_reorder, j: disp_j, k: disp_k};
      end
`ifndef SYNTHESIS
      if (disp_en && full) $display("reservation_station: error, dispatch while full ignored at %0t", $time);
`endif
    end
  end

`ifdef RS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_full_cnt  <= '0;
    end else if (rdy) begin
      if (full) perf_full_cnt <= perf_full_cnt + 32'd1;
      if (!clear && ready_valid) perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif
endmodule
